// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Brief    : ID/EX pipeline register with load-use hazard detection.
//            Optional macro IDEX_STALL_CNT_EN adds stall/flush event counters.
// Revision : 1.0
// ============================================================================
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int RIDX = 5
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            id_valid_i,
    input  logic            id_RegWrite_i,
    input  logic            id_MemWrite_i,
    input  logic [5:0]      id_EXTOp_i,
    input  logic [4:0]      id_ALUOp_i,
    input  logic [2:0]      id_NPCOp_i,
    input  logic            id_ALUSrc_i,
    input  logic [1:0]      id_WDSel_i,
    input  logic [2:0]      id_DMType_i,
    input  logic [XLEN-1:0] id_pc_i,
    input  logic [XLEN-1:0] id_rd1_i,
    input  logic [XLEN-1:0] id_rd2_i,
    input  logic [XLEN-1:0] id_imm_i,
    input  logic [RIDX-1:0] id_rs1_i,
    input  logic [RIDX-1:0] id_rs2_i,
    input  logic [RIDX-1:0] id_rd_i,
    input  logic            id_rs1_used_i,
    input  logic            id_rs2_used_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            ex_valid_o,
    output logic            ex_RegWrite_o,
    output logic            ex_MemWrite_o,
    output logic [5:0]      ex_EXTOp_o,
    output logic [4:0]      ex_ALUOp_o,
    output logic [2:0]      ex_NPCOp_o,
    output logic            ex_ALUSrc_o,
    output logic [1:0]      ex_WDSel_o,
    output logic [2:0]      ex_DMType_o,
    output logic [XLEN-1:0] ex_pc_o,
    output logic [XLEN-1:0] ex_rd1_o,
    output logic [XLEN-1:0] ex_rd2_o,
    output logic [XLEN-1:0] ex_imm_o,
    output logic [RIDX-1:0] ex_rs1_o,
    output logic [RIDX-1:0] ex_rs2_o,
    output logic [RIDX-1:0] ex_rd_o
`ifdef IDEX_STALL_CNT_EN
    ,
    output logic [31:0]     stall_cnt_o,
    output logic [31:0]     flush_cnt_o
`endif
);

    localparam logic [1:0] c_WDSEL_LOAD = 2'b01;

    logic            r_valid;
    logic            r_regwrite;
    logic            r_memwrite;
    logic [5:0]      r_extop;
    logic [4:0]      r_aluop;
    logic [2:0]      r_npcop;
    logic            r_alusrc;
    logic [1:0]      r_wdsel;
    logic [2:0]      r_dmtype;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rd1;
    logic [XLEN-1:0] r_rd2;
    logic [XLEN-1:0] r_imm;
    logic [RIDX-1:0] r_rs1;
    logic [RIDX-1:0] r_rs2;
    logic [RIDX-1:0] r_rd;

    logic w_ex_is_load;
    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_load_use;
    logic w_bubble;

    // The loaded value is not ready until after MEM, so a dependent ID
    // instruction must wait one cycle; x0 never carries a real dependency.
    assign w_ex_is_load = r_valid && (r_wdsel == c_WDSEL_LOAD) && (r_rd != '0);
    assign w_rs1_hit    = id_rs1_used_i && (id_rs1_i == r_rd);
    assign w_rs2_hit    = id_rs2_used_i && (id_rs2_i == r_rd);
    assign w_load_use   = w_ex_is_load && id_valid_i && (w_rs1_hit || w_rs2_hit);
    assign stall_o      = w_load_use && !flush_i;

    // Flush, load-use and an empty ID slot all collapse to the same bubble.
    assign w_bubble = flush_i || w_load_use || !id_valid_i;

    always_ff @(posedge clk) begin
        if (!rstn || w_bubble) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_memwrite <= 1'b0;
            r_extop    <= '0;
            r_aluop    <= '0;
            r_npcop    <= '0;
            r_alusrc   <= 1'b0;
            r_wdsel    <= '0;
            r_dmtype   <= '0;
            r_pc       <= '0;
            r_rd1      <= '0;
            r_rd2      <= '0;
            r_imm      <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
        end else begin
            r_valid    <= 1'b1;
            r_regwrite <= id_RegWrite_i;
            r_memwrite <= id_MemWrite_i;
            r_extop    <= id_EXTOp_i;
            r_aluop    <= id_ALUOp_i;
            r_npcop    <= id_NPCOp_i;
            r_alusrc   <= id_ALUSrc_i;
            r_wdsel    <= id_WDSel_i;
            r_dmtype   <= id_DMType_i;
            r_pc       <= id_pc_i;
            r_rd1      <= id_rd1_i;
            r_rd2      <= id_rd2_i;
            r_imm      <= id_imm_i;
            r_rs1      <= id_rs1_i;
            r_rs2      <= id_rs2_i;
            r_rd       <= id_rd_i;
        end
    end

    assign ex_valid_o    = r_valid;
    assign ex_RegWrite_o = r_regwrite;
    assign ex_MemWrite_o = r_memwrite;
    assign ex_EXTOp_o    = r_extop;
    assign ex_ALUOp_o    = r_aluop;
    assign ex_NPCOp_o    = r_npcop;
    assign ex_ALUSrc_o   = r_alusrc;
    assign ex_WDSel_o    = r_wdsel;
    assign ex_DMType_o   = r_dmtype;
    assign ex_pc_o       = r_pc;
    assign ex_rd1_o      = r_rd1;
    assign ex_rd2_o      = r_rd2;
    assign ex_imm_o      = r_imm;
    assign ex_rs1_o      = r_rs1;
    assign ex_rs2_o      = r_rs2;
    assign ex_rd_o       = r_rd;

`ifdef IDEX_STALL_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // Free-running event counters; wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stall_o) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (flush_i) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Brief    : Directed self-checking bench for id_ex_stage with a cycle model.
// Revision : 1.0
// ============================================================================
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic        rw;
        logic        mw;
        logic [5:0]  ext;
        logic [4:0]  alu;
        logic [2:0]  npc;
        logic        alusrc;
        logic [1:0]  wdsel;
        logic [2:0]  dm;
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rs1u;
        logic        rs2u;
    } slot_t;

    logic  clk = 1'b0;
    logic  rstn = 1'b0;
    logic  flush = 1'b0;
    slot_t id;

    logic        stall;
    logic        ex_valid, ex_rw, ex_mw, ex_alusrc;
    logic [5:0]  ex_ext;
    logic [4:0]  ex_alu;
    logic [2:0]  ex_npc, ex_dm;
    logic [1:0]  ex_wdsel;
    logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
`ifdef IDEX_STALL_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32), .RIDX(5)) dut (
        .clk(clk), .rstn(rstn),
        .id_valid_i(id.valid), .id_RegWrite_i(id.rw), .id_MemWrite_i(id.mw),
        .id_EXTOp_i(id.ext), .id_ALUOp_i(id.alu), .id_NPCOp_i(id.npc),
        .id_ALUSrc_i(id.alusrc), .id_WDSel_i(id.wdsel), .id_DMType_i(id.dm),
        .id_pc_i(id.pc), .id_rd1_i(id.rd1), .id_rd2_i(id.rd2), .id_imm_i(id.imm),
        .id_rs1_i(id.rs1), .id_rs2_i(id.rs2), .id_rd_i(id.rd),
        .id_rs1_used_i(id.rs1u), .id_rs2_used_i(id.rs2u),
        .flush_i(flush), .stall_o(stall),
        .ex_valid_o(ex_valid), .ex_RegWrite_o(ex_rw), .ex_MemWrite_o(ex_mw),
        .ex_EXTOp_o(ex_ext), .ex_ALUOp_o(ex_alu), .ex_NPCOp_o(ex_npc),
        .ex_ALUSrc_o(ex_alusrc), .ex_WDSel_o(ex_wdsel), .ex_DMType_o(ex_dm),
        .ex_pc_o(ex_pc), .ex_rd1_o(ex_rd1), .ex_rd2_o(ex_rd2), .ex_imm_o(ex_imm),
        .ex_rs1_o(ex_rs1), .ex_rs2_o(ex_rs2), .ex_rd_o(ex_rd)
`ifdef IDEX_STALL_CNT_EN
        , .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
`endif
    );

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    slot_t m;
    logic  armed = 1'b0;
    int    m_scnt = 0;
    int    m_fcnt = 0;
    int    preload_req = 0;
    int    preload_seen = 0;

    function automatic logic hazard(input slot_t e, input slot_t d, input logic fl);
        logic dep;
        dep = (d.rs1u && d.rs1 == e.rd) || (d.rs2u && d.rs2 == e.rd);
        return e.valid && e.wdsel == 2'b01 && e.rd != 5'd0 && d.valid && dep && !fl;
    endfunction

    function automatic logic dependent(input slot_t e, input slot_t d);
        return e.valid && e.wdsel == 2'b01 && e.rd != 5'd0 && d.valid &&
               ((d.rs1u && d.rs1 == e.rd) || (d.rs2u && d.rs2 == e.rd));
    endfunction

    always @(posedge clk) begin
        int base;
        base = (preload_req != preload_seen) ? -1 : m_scnt;
        preload_seen = preload_req;
        if (!rstn) begin
            m = '0;
            m_scnt = 0;
            m_fcnt = 0;
        end else begin
            if (hazard(m, id, flush)) m_scnt = base + 1;
            else                      m_scnt = base;
            if (flush) m_fcnt = m_fcnt + 1;
            if (flush || dependent(m, id) || !id.valid) begin
                m = '0;
            end else begin
                m = id;
                m.rs1u = 1'b0;
                m.rs2u = 1'b0;
            end
        end
        armed = 1'b1;
    end

    always @(negedge clk) begin
        if (armed) begin
            cmp("m_stall",    {31'd0, stall},    {31'd0, hazard(m, id, flush)});
            cmp("m_valid",    {31'd0, ex_valid}, {31'd0, m.valid});
            cmp("m_regwrite", {31'd0, ex_rw},    {31'd0, m.rw});
            cmp("m_memwrite", {31'd0, ex_mw},    {31'd0, m.mw});
            cmp("m_extop",    {26'd0, ex_ext},   {26'd0, m.ext});
            cmp("m_aluop",    {27'd0, ex_alu},   {27'd0, m.alu});
            cmp("m_npcop",    {29'd0, ex_npc},   {29'd0, m.npc});
            cmp("m_alusrc",   {31'd0, ex_alusrc},{31'd0, m.alusrc});
            cmp("m_wdsel",    {30'd0, ex_wdsel}, {30'd0, m.wdsel});
            cmp("m_dmtype",   {29'd0, ex_dm},    {29'd0, m.dm});
            cmp("m_pc",       ex_pc,  m.pc);
            cmp("m_rd1",      ex_rd1, m.rd1);
            cmp("m_rd2",      ex_rd2, m.rd2);
            cmp("m_imm",      ex_imm, m.imm);
            cmp("m_rs1",      {27'd0, ex_rs1},   {27'd0, m.rs1});
            cmp("m_rs2",      {27'd0, ex_rs2},   {27'd0, m.rs2});
            cmp("m_rd",       {27'd0, ex_rd},    {27'd0, m.rd});
`ifdef IDEX_STALL_CNT_EN
            cmp("m_stall_cnt", stall_cnt,
                (preload_req != preload_seen) ? 32'hFFFF_FFFF : 32'(m_scnt));
            cmp("m_flush_cnt", flush_cnt, 32'(m_fcnt));
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic slot_t mk_alu(input logic [31:0] pc, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
        slot_t s = '0;
        s.valid = 1'b1; s.rw = 1'b1; s.alu = 5'b00010; s.pc = pc;
        s.rd1 = pc ^ 32'h1111_0000; s.rd2 = pc ^ 32'h0000_2222;
        s.rs1 = rs1; s.rs2 = rs2; s.rd = rd; s.rs1u = 1'b1; s.rs2u = 1'b1;
        return s;
    endfunction

    function automatic slot_t mk_load(input logic [31:0] pc, input logic [4:0] rd,
                                      input logic [4:0] rs1);
        slot_t s = '0;
        s.valid = 1'b1; s.rw = 1'b1; s.ext = 6'b010000; s.alu = 5'b00011;
        s.alusrc = 1'b1; s.wdsel = 2'b01; s.dm = 3'b010; s.pc = pc;
        s.rd1 = 32'h0000_1000; s.imm = 32'h4; s.rs1 = rs1; s.rd = rd; s.rs1u = 1'b1;
        return s;
    endfunction

    function automatic slot_t mk_itype(input logic [31:0] pc, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2f);
        slot_t s = '0;
        s.valid = 1'b1; s.rw = 1'b1; s.ext = 6'b010000; s.alu = 5'b00011;
        s.alusrc = 1'b1; s.pc = pc; s.imm = 32'h7; s.rs1 = rs1; s.rs2 = rs2f;
        s.rd = rd; s.rs1u = 1'b1; s.rs2u = 1'b0;
        return s;
    endfunction

    function automatic slot_t mk_store(input logic [31:0] pc, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [31:0] data);
        slot_t s = '0;
        s.valid = 1'b1; s.mw = 1'b1; s.ext = 6'b001000; s.alu = 5'b00011;
        s.npc = 3'b001; s.alusrc = 1'b1; s.dm = 3'b000; s.pc = pc;
        s.rd1 = 32'h0000_2000; s.rd2 = data; s.imm = 32'h8;
        s.rs1 = rs1; s.rs2 = rs2; s.rs1u = 1'b1; s.rs2u = 1'b1;
        return s;
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        id = slot_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});

        // Reset held for two edges with random ID contents.
        tick();
        id = slot_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        tick();
        cmp("rst_valid", {31'd0, ex_valid}, 32'd0);
        cmp("rst_pc",    ex_pc,  32'd0);
        cmp("rst_rd2",   ex_rd2, 32'd0);
        cmp("rst_npcop", {29'd0, ex_npc}, 32'd0);
        cmp("rst_stall", {31'd0, stall},  32'd0);

        // Release: lw x5 at 0x10 is captured on the next edge.
        rstn = 1'b1;
        id = mk_load(32'h10, 5'd5, 5'd1);
        tick();
        cmp("lw_pc",    ex_pc, 32'h10);
        cmp("lw_wdsel", {30'd0, ex_wdsel}, 32'd1);

        // Load-use: add x6, x5, x2 at 0x14 stalls exactly one cycle.
        id = mk_alu(32'h14, 5'd6, 5'd5, 5'd2);
        #1;
        cmp("lu_stall", {31'd0, stall}, 32'd1);
        tick();
        cmp("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
        cmp("lu_bubble_rw",    {31'd0, ex_rw},    32'd0);
        cmp("lu_stall_gone",   {31'd0, stall},    32'd0);
        tick();
        cmp("lu_add_pc",    ex_pc, 32'h14);
        cmp("lu_add_valid", {31'd0, ex_valid}, 32'd1);

        // x0 destination never stalls.
        id = mk_load(32'h18, 5'd0, 5'd1);
        tick();
        id = mk_alu(32'h1c, 5'd3, 5'd0, 5'd2);
        #1;
        cmp("x0_stall", {31'd0, stall}, 32'd0);
        tick();

        // Unused rs2 field matching the load rd does not stall.
        id = mk_load(32'h20, 5'd7, 5'd1);
        tick();
        id = mk_itype(32'h24, 5'd8, 5'd3, 5'd7);
        #1;
        cmp("unused_rs2_stall", {31'd0, stall}, 32'd0);
        tick();
        cmp("unused_rs2_pc", ex_pc, 32'h24);

        // Flush beats stall: dependent store with flush -> bubble.
        id = mk_load(32'h28, 5'd9, 5'd1);
        tick();
        id = mk_store(32'h2c, 5'd2, 5'd9, 32'h1234_5678);
        flush = 1'b1;
        #1;
        cmp("flush_stall", {31'd0, stall}, 32'd0);
        tick();
        flush = 1'b0;
        cmp("flush_valid", {31'd0, ex_valid}, 32'd0);
        cmp("flush_npcop", {29'd0, ex_npc},   32'd0);
        cmp("flush_mw",    {31'd0, ex_mw},    32'd0);

        // Pass-through of a store.
        id = mk_store(32'h44, 5'd2, 5'd6, 32'hDEAD_BEEF);
        tick();
        cmp("pt_rd2",   ex_rd2, 32'hDEAD_BEEF);
        cmp("pt_aluop", {27'd0, ex_alu}, 32'h3);
        cmp("pt_extop", {26'd0, ex_ext}, 32'h8);
        cmp("pt_dm",    {29'd0, ex_dm},  32'h0);
        cmp("pt_mw",    {31'd0, ex_mw},  32'h1);
        cmp("pt_imm",   ex_imm, 32'h8);

        // Back-to-back loads into x4, each stalling its dependent once.
        id = mk_load(32'h48, 5'd4, 5'd1);
        tick();
        id = mk_load(32'h4c, 5'd4, 5'd4);
        #1;
        cmp("b2b_stall1", {31'd0, stall}, 32'd1);
        tick();
        tick();
        cmp("b2b_second_pc", ex_pc, 32'h4c);
        id = mk_alu(32'h50, 5'd10, 5'd4, 5'd4);
        #1;
        cmp("b2b_stall2", {31'd0, stall}, 32'd1);
        tick();
        tick();
        cmp("b2b_add_pc", ex_pc, 32'h50);

        // Empty ID slot is captured as a bubble.
        id = mk_alu(32'h54, 5'd11, 5'd1, 5'd2);
        id.valid = 1'b0;
        id.npc = 3'b010;
        tick();
        cmp("nv_valid", {31'd0, ex_valid}, 32'd0);
        cmp("nv_rw",    {31'd0, ex_rw},    32'd0);
        cmp("nv_npcop", {29'd0, ex_npc},   32'd0);

        // Reset in the middle of a stall discards everything.
        id = mk_load(32'h58, 5'd5, 5'd1);
        tick();
        id = mk_alu(32'h5c, 5'd6, 5'd5, 5'd2);
        #1;
        cmp("rs_mid_stall", {31'd0, stall}, 32'd1);
        rstn = 1'b0;
        tick();
        cmp("rs_mid_valid", {31'd0, ex_valid}, 32'd0);
        cmp("rs_mid_pc",    ex_pc, 32'd0);
        cmp("rs_mid_stall0", {31'd0, stall}, 32'd0);
        rstn = 1'b1;
        tick();
        cmp("rs_mid_after_pc", ex_pc, 32'h5c);

`ifdef IDEX_STALL_CNT_EN
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            id = mk_load(32'h100 + 32'(k * 16), 5'd5, 5'd1);
            tick();
            id = mk_alu(32'h104 + 32'(k * 16), 5'd6, 5'd5, 5'd2);
            tick();
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            flush = 1'b1;
            tick();
            flush = 1'b0;
            tick();
        end
        cmp("cnt_stall3", stall_cnt, 32'd3);
        cmp("cnt_flush2", flush_cnt, 32'd2);
        id = mk_load(32'h200, 5'd5, 5'd1);
        tick();
        force dut.r_stall_cnt = 32'hFFFF_FFFF;
        preload_req = preload_req + 1;
        #1;
        release dut.r_stall_cnt;
        id = mk_alu(32'h204, 5'd6, 5'd5, 5'd2);
        tick();
        cmp("cnt_wrap", stall_cnt, 32'd0);
        tick();
`endif

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
